// File: rtl/exe_ctrl_pkg.sv
// exe_ctrl_pkg
// Shared encodings for the MIPS execute-stage sequencer:
//   - opcode / R-type funct values the decoder recognises
//   - ALU operation codes driven on alu_control
//   - sequencer state enumeration
package exe_ctrl_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_ADDU = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        BR_WAIT = 2'd2,
        BR_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/exe_decode.sv
// exe_decode
// Purely combinational instruction decoder for the execute stage.
// Ports:
//   opcode, funct      in   instruction[31:26] and instruction[5:0]
//   alu_control        out  ALU operation code
//   alu_src            out  1 = immediate operand, 0 = read data 2
//   reg_dst            out  1 = rd, 0 = rt
//   reg_write          out  writeback enable
//   mem_read/mem_write out  memory enables
//   is_branch          out  instruction is beq
//   illegal            out  encoding not supported (all other outputs 0)
module exe_decode
    import exe_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       is_branch,
    output logic       illegal
);

    // Opcode/funct table; unsupported encodings leave every control at 0.
    always_comb begin
        alu_control = ALU_ADD;
        alu_src     = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        is_branch   = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_NOR:  alu_control = ALU_NOR;
                    FN_ADDU: alu_control = ALU_ADDU;
                    FN_SUB:  alu_control = ALU_SUB;
                    default: begin
                        // Unknown funct: retract the R-type defaults too.
                        reg_dst   = 1'b0;
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                alu_control = ALU_ADD;
                alu_src     = 1'b1;
                reg_write   = 1'b1;
            end
            OP_ANDI: begin
                alu_control = ALU_AND;
                alu_src     = 1'b1;
                reg_write   = 1'b1;
            end
            OP_ORI: begin
                alu_control = ALU_OR;
                alu_src     = 1'b1;
                reg_write   = 1'b1;
            end
            OP_LW: begin
                alu_control = ALU_ADD;
                alu_src     = 1'b1;
                mem_read    = 1'b1;
                reg_write   = 1'b1;
            end
            OP_SW: begin
                alu_control = ALU_ADD;
                alu_src     = 1'b1;
                mem_write   = 1'b1;
            end
            OP_BEQ: begin
                alu_control = ALU_SUB;
                is_branch   = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/exe_ctrl.sv
// exe_ctrl
// Execute-stage sequencer: accepts one decoded instruction per handshake,
// holds its controls while the ALU works, waits one extra cycle for the
// registered branch flag on beq, then hands off to EX/MEM.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        ID/EX handshake
//   opcode, funct              instruction fields
//   zero_flag                  registered branch flag from the datapath
//   out_valid / out_ready      EX/MEM handshake
//   alu_src, alu_control, reg_dst, alu_enable   EXE datapath controls
//   reg_write, mem_read, mem_write              downstream enables
//   branch_taken, flush        branch resolution and IF/ID squash pulse
//   illegal                    one-cycle pulse on unsupported encoding
//   retired_cnt, taken_cnt     wrapping event counters
module exe_ctrl
    import exe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             alu_src,
    output logic [3:0]       alu_control,
    output logic             reg_dst,
    output logic             alu_enable,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch_taken,
    output logic             flush,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Decoder outputs for the instruction currently on the input
    logic [3:0] dec_alu_control_s;
    logic       dec_alu_src_s;
    logic       dec_reg_dst_s;
    logic       dec_reg_write_s;
    logic       dec_mem_read_s;
    logic       dec_mem_write_s;
    logic       dec_is_branch_s;
    logic       dec_illegal_s;

    state_t     state_r;
    state_t     next_state_s;
    logic       armed_r;
    logic       in_ready_s;
    logic       accept_s;
    logic       handshake_s;
    logic       load_s;
    logic       retire_s;

    logic [3:0] alu_control_r;
    logic       alu_src_r;
    logic       reg_dst_r;
    logic       reg_write_r;
    logic       mem_read_r;
    logic       mem_write_r;
    logic       out_valid_r;
    logic       alu_enable_r;
    logic       branch_taken_r;
    logic       illegal_r;
    logic [CNT_W-1:0] retired_cnt_r;
    logic [CNT_W-1:0] taken_cnt_r;

    exe_decode u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .alu_control (dec_alu_control_s),
        .alu_src     (dec_alu_src_s),
        .reg_dst     (dec_reg_dst_s),
        .reg_write   (dec_reg_write_s),
        .mem_read    (dec_mem_read_s),
        .mem_write   (dec_mem_write_s),
        .is_branch   (dec_is_branch_s),
        .illegal     (dec_illegal_s)
    );

    // armed_r keeps in_ready low while reset is asserted and for the first
    // edge after release, so every output reads 0 during reset.
    assign in_ready_s  = armed_r && ((state_r == IDLE) ||
                                     ((state_r == EXEC) && out_ready));
    assign accept_s    = in_valid && in_ready_s;
    assign handshake_s = out_valid_r && out_ready;
    assign retire_s    = handshake_s;

    // Next-state logic; also decides when the holding register loads.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && !dec_illegal_s) begin
                    load_s       = 1'b1;
                    next_state_s = dec_is_branch_s ? BR_WAIT : EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: begin
                if (handshake_s) begin
                    // in_ready mirrors out_ready here, so accept implies retire.
                    if (accept_s && !dec_illegal_s) begin
                        load_s       = 1'b1;
                        next_state_s = dec_is_branch_s ? BR_WAIT : EXEC;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = EXEC;
                end
            end
            BR_WAIT: begin
                next_state_s = BR_DONE;
            end
            BR_DONE: begin
                if (handshake_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = BR_DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and post-reset arming flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            armed_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            armed_r <= 1'b1;
        end
    end

    // Holding register for the decoded controls; cleared whenever idle so
    // downstream enables never linger after a retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_control_r <= ALU_ADD;
            alu_src_r     <= 1'b0;
            reg_dst_r     <= 1'b0;
            reg_write_r   <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
        end else if (load_s) begin
            alu_control_r <= dec_alu_control_s;
            alu_src_r     <= dec_alu_src_s;
            reg_dst_r     <= dec_reg_dst_s;
            reg_write_r   <= dec_reg_write_s;
            mem_read_r    <= dec_mem_read_s;
            mem_write_r   <= dec_mem_write_s;
        end else if (next_state_s == IDLE) begin
            alu_control_r <= ALU_ADD;
            alu_src_r     <= 1'b0;
            reg_dst_r     <= 1'b0;
            reg_write_r   <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
        end else begin
            alu_control_r <= alu_control_r;
            alu_src_r     <= alu_src_r;
            reg_dst_r     <= reg_dst_r;
            reg_write_r   <= reg_write_r;
            mem_read_r    <= mem_read_r;
            mem_write_r   <= mem_write_r;
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            alu_enable_r <= 1'b0;
            illegal_r    <= 1'b0;
        end else begin
            out_valid_r  <= (next_state_s == EXEC) || (next_state_s == BR_DONE);
            alu_enable_r <= (next_state_s != IDLE);
            illegal_r    <= accept_s && dec_illegal_s;
        end
    end

    // Branch outcome: sampled once on the BR_WAIT->BR_DONE edge (the first
    // cycle zero_flag is valid) and frozen until the branch leaves BR_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_taken_r <= 1'b0;
        end else if (state_r == BR_WAIT) begin
            branch_taken_r <= zero_flag;
        end else if (next_state_s != BR_DONE) begin
            branch_taken_r <= 1'b0;
        end else begin
            branch_taken_r <= branch_taken_r;
        end
    end

    // Retire and taken-branch counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_r <= {CNT_W{1'b0}};
            taken_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (retire_s) begin
                retired_cnt_r <= retired_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_cnt_r <= retired_cnt_r;
            end
            if (retire_s && (state_r == BR_DONE) && branch_taken_r) begin
                taken_cnt_r <= taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                taken_cnt_r <= taken_cnt_r;
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign alu_src      = alu_src_r;
    assign alu_control  = alu_control_r;
    assign reg_dst      = reg_dst_r;
    assign alu_enable   = alu_enable_r;
    assign reg_write    = reg_write_r;
    assign mem_read     = mem_read_r;
    assign mem_write    = mem_write_r;
    assign branch_taken = branch_taken_r;
    // flush must coincide with the handshake, so it follows out_ready directly.
    assign flush        = handshake_s && (state_r == BR_DONE) && branch_taken_r;
    assign illegal      = illegal_r;
    assign retired_cnt  = retired_cnt_r;
    assign taken_cnt    = taken_cnt_r;

endmodule
